// File: rtl/column_loader_pkg.sv
// column_loader_pkg: shared definitions for the column loader slice.
//   - state_t      : loader FSM states
//   - DEFAULT_*    : default bitmap width and columns per frame
//   - idx_width()  : width of the column index for a given column count
package column_loader_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_COLS  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_CLEAR
    } state_t;

    // A single-column store still needs a 1-bit index register.
    function automatic int idx_width(input int cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

endpackage

// File: rtl/column_fifo.sv
// column_fifo: synchronous FIFO buffering incoming column bitmaps.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (empties FIFO)
//   push, push_data       write request and data (ignored when full)
//   pop, head             read request (ignored when empty); head is the
//                         oldest entry, valid while !empty
//   full, empty           current occupancy flags
//   full_next, empty_next occupancy flags as they will be after this edge,
//                         used by the parent to build registered status
// DEPTH must be a power of two (pointers wrap naturally), minimum 2.
module column_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             full_next,
    output logic             empty_next
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_next = count;
        unique case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);
    assign full_next  = (count_next == FULL_COUNT);
    assign empty_next = (count_next == '0);
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/column_loader.sv
// column_loader: upstream feeder for the dot-matrix column store.
// Buffers column bitmaps from a valid/ready source and replays each one onto
// the store's in_column/LOAD interface with setup/hold around the LOAD
// falling edge (where the store latches and advances its column counter).
// Also sequences IN_CLR frame clears and mirrors the store's column index.
// Ports:
//   CLK, RESET            system clock, asynchronous active-low reset
//   col_data, col_valid   incoming column bitmap and its valid flag
//   col_ready             registered !fifo_full; transfer on valid && ready
//   frame_clear           single-cycle clear request (merged while pending)
//   in_column, LOAD       column bitmap and load strobe to the store
//   IN_CLR                clear strobe to the store
//   column_idx            column the next LOAD falling edge writes
//   frame_done            one-cycle pulse when the last column is loaded
//   busy                  FSM active, FIFO non-empty or clear pending
module column_loader
    import column_loader_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int COLS       = DEFAULT_COLS,
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 1,
    parameter int LOAD_HIGH  = 2,
    parameter int HOLD_CYC   = 1,
    parameter int CLR_CYCLES = 2,
    localparam int IW = idx_width(COLS)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] col_data,
    input  logic             col_valid,
    output logic             col_ready,
    input  logic             frame_clear,
    output logic [WIDTH-1:0] in_column,
    output logic             LOAD,
    output logic             IN_CLR,
    output logic [IW-1:0]    column_idx,
    output logic             frame_done,
    output logic             busy
);

    localparam int M1   = (SETUP_CYC > LOAD_HIGH) ? SETUP_CYC : LOAD_HIGH;
    localparam int M2   = (HOLD_CYC > CLR_CYCLES) ? HOLD_CYC : CLR_CYCLES;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int TW   = $clog2(MAXC + 1);

    localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(LOAD_HIGH - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] CLR_LAST   = TW'(CLR_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(COLS - 1);

    state_t           state, state_next;
    logic [TW-1:0]    timer, timer_next;
    logic             clr_pending, clr_pending_next;
    logic [WIDTH-1:0] in_column_next;
    logic [IW-1:0]    column_idx_next;
    logic             load_next, in_clr_next, frame_done_next, busy_next;
    logic             idx_step;

    logic             push, pop;
    logic [WIDTH-1:0] fifo_head;
    logic             fifo_full, fifo_empty, fifo_full_next, fifo_empty_next;

    assign push = col_valid && col_ready && !fifo_full;

    column_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (RESET),
        .push       (push),
        .push_data  (col_data),
        .pop        (pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .full_next  (fifo_full_next),
        .empty_next (fifo_empty_next)
    );

    // Next-state, timer and FIFO pop.
    always_comb begin
        state_next = state;
        timer_next = timer + 1'b1;
        pop        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                timer_next = '0;
                if (clr_pending) begin
                    state_next = ST_CLEAR;
                end else if (!fifo_empty) begin
                    state_next = ST_SETUP;
                    pop        = 1'b1;
                end
            end
            ST_SETUP: begin
                if (timer == SETUP_LAST) begin
                    state_next = ST_PULSE;
                    timer_next = '0;
                end
            end
            ST_PULSE: begin
                if (timer == PULSE_LAST) begin
                    state_next = ST_HOLD;
                    timer_next = '0;
                end
            end
            ST_HOLD: begin
                if (timer == HOLD_LAST) begin
                    state_next = ST_IDLE;
                    timer_next = '0;
                end
            end
            ST_CLEAR: begin
                if (timer == CLR_LAST) begin
                    state_next = ST_IDLE;
                    timer_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                timer_next = '0;
            end
        endcase
    end

    // Output next values. Strobes are decoded from the next state so that
    // the registered LOAD/IN_CLR track the state register exactly and can
    // never overlap.
    always_comb begin
        in_column_next  = pop ? fifo_head : in_column;
        load_next       = (state_next == ST_PULSE);
        in_clr_next     = (state_next == ST_CLEAR);
        idx_step        = (state == ST_PULSE) && (state_next == ST_HOLD);
        column_idx_next = column_idx;
        if (idx_step) begin
            column_idx_next = (column_idx == IDX_LAST) ? '0 : column_idx + 1'b1;
        end
        frame_done_next = idx_step && (column_idx == IDX_LAST);
        // A request landing on the IDLE->CLEAR edge is served by that clear.
        clr_pending_next = (state == ST_IDLE && clr_pending) ? 1'b0
                                                             : (clr_pending | frame_clear);
        busy_next = (state_next != ST_IDLE) || !fifo_empty_next || clr_pending_next;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= ST_IDLE;
            timer       <= '0;
            clr_pending <= 1'b0;
            in_column   <= '0;
            LOAD        <= 1'b0;
            IN_CLR      <= 1'b0;
            column_idx  <= '0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            col_ready   <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            clr_pending <= clr_pending_next;
            in_column   <= in_column_next;
            LOAD        <= load_next;
            IN_CLR      <= in_clr_next;
            column_idx  <= column_idx_next;
            frame_done  <= frame_done_next;
            busy        <= busy_next;
            col_ready   <= !fifo_full_next;
        end
    end

endmodule
